mul_unit_mc: RTL and testbench



---
 rtl/mul_unit_mc.sv | 139 +++++++++++++
 tb/tb_mul_unit_mc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit_mc.sv
// Iterative radix-2 shift-add multiplier (MUL/MLA/UMULL/SMULL) for the multicycle core.
// Takes WIDTH RUN cycles plus one FIX cycle, then pulses Done with registered result and {N,Z}.
module mul_unit_mc #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [WIDTH-1:0] SrcC,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic [1:0]       Flags
);

   localparam logic [1:0] MODE_MLA   = 2'b01;
   localparam logic [1:0] MODE_SMULL = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;

   state_t             state_reg, state_next;
   logic               accept;
   logic               busy_reg, done_reg;
   logic [CNTW-1:0]    count_reg;
   logic [1:0]         mode_reg;
   logic               neg_reg;
   logic [WIDTH-1:0]   mcand_reg, mplr_reg, addend_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   lo_reg, hi_reg;
   logic [1:0]         flags_reg;

   logic [WIDTH-1:0]   a_abs, b_abs, partial;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   fix_lo, fix_hi;
   logic               fix_n, fix_z;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next == ST_RUN) || (state_next == ST_FIX);
         done_reg  <= (state_next == ST_DONE);
      end
   end

   // Start is only looked at in IDLE and DONE; in RUN/FIX it is dropped, not queued.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (Start) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (count_reg == '0) state_next = ST_FIX;
         end
         ST_FIX: state_next = ST_DONE;
         ST_DONE: begin
            if (Start) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Magnitudes for SMULL; the most negative value maps onto unsigned 2^(W-1).
   assign a_abs   = SrcA[WIDTH-1] ? -SrcA : SrcA;
   assign b_abs   = SrcB[WIDTH-1] ? -SrcB : SrcB;
   assign partial = mplr_reg[0] ? mcand_reg : '0;
   assign sum     = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, partial};

   assign product = neg_reg ? -acc_reg : acc_reg;
   assign fix_lo  = (mode_reg == MODE_MLA) ? (acc_reg[WIDTH-1:0] + addend_reg)
                                           : product[WIDTH-1:0];
   assign fix_hi  = mode_reg[1] ? product[2*WIDTH-1:WIDTH] : '0;
   assign fix_n   = mode_reg[1] ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1];
   assign fix_z   = mode_reg[1] ? ~|{fix_hi, fix_lo} : ~|fix_lo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg  <= '0;
         mode_reg   <= '0;
         neg_reg    <= 1'b0;
         mcand_reg  <= '0;
         mplr_reg   <= '0;
         addend_reg <= '0;
         acc_reg    <= '0;
         lo_reg     <= '0;
         hi_reg     <= '0;
         flags_reg  <= '0;
      end else if (accept) begin
         mode_reg   <= Mode;
         addend_reg <= SrcC;
         acc_reg    <= '0;
         count_reg  <= CNTW'(WIDTH - 1);
         if (Mode == MODE_SMULL) begin
            mcand_reg <= a_abs;
            mplr_reg  <= b_abs;
            neg_reg   <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
         end else begin
            mcand_reg <= SrcA;
            mplr_reg  <= SrcB;
            neg_reg   <= 1'b0;
         end
      end else if (state_reg == ST_RUN) begin
         // Carry out of the upper-half add shifts into the top bit of the accumulator.
         acc_reg   <= {sum, acc_reg[WIDTH-1:1]};
         mplr_reg  <= mplr_reg >> 1;
         count_reg <= count_reg - CNTW'(1);
      end else if (state_reg == ST_FIX) begin
         lo_reg    <= fix_lo;
         hi_reg    <= fix_hi;
         flags_reg <= {fix_n, fix_z};
      end
   end

   assign Busy     = busy_reg;
   assign Done     = done_reg;
   assign ResultLo = lo_reg;
   assign ResultHi = hi_reg;
   assign Flags    = flags_reg;

endmodule

// File: tb/tb_mul_unit_mc.sv
// Directed table plus multicycle corner sequences for mul_unit_mc at WIDTH=32,
// and a random sweep of WIDTH=4 and WIDTH=64 instances against a behavioural product model.
module tb_mul_unit_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [31:0] a, b, c;
   logic        busy, done;
   logic [31:0] lo, hi;
   logic [1:0]  flags;

   logic        s_start;
   logic [1:0]  s_mode;
   logic [63:0] s_a, s_b, s_c;
   logic        busy4, done4, busy64, done64;
   logic [3:0]  lo4, hi4;
   logic [63:0] lo64, hi64;
   logic [1:0]  fl4, fl64;

   always #5 clk = ~clk;

   mul_unit_mc #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .Start(start), .Mode(mode),
      .SrcA(a), .SrcB(b), .SrcC(c),
      .Busy(busy), .Done(done), .ResultLo(lo), .ResultHi(hi), .Flags(flags));

   mul_unit_mc #(.WIDTH(4)) u4 (
      .clk(clk), .reset(reset), .Start(s_start), .Mode(s_mode),
      .SrcA(s_a[3:0]), .SrcB(s_b[3:0]), .SrcC(s_c[3:0]),
      .Busy(busy4), .Done(done4), .ResultLo(lo4), .ResultHi(hi4), .Flags(fl4));

   mul_unit_mc #(.WIDTH(64)) u64 (
      .clk(clk), .reset(reset), .Start(s_start), .Mode(s_mode),
      .SrcA(s_a), .SrcB(s_b), .SrcC(s_c),
      .Busy(busy64), .Done(done64), .ResultLo(lo64), .ResultHi(hi64), .Flags(fl64));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] a, b, c;
      logic [31:0] lo, hi;
      logic [1:0]  fl;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   // Issues one op from a negedge; scrambles sources after E0 and optionally pulses Start mid-RUN.
   task automatic run_op(input logic [1:0] m, input logic [31:0] ia, ib, ic, input int inject_at,
                         output int lat, output int busy_cnt);
      mode = m; a = ia; b = ib; c = ic; start = 1'b1;
      @(posedge clk);
      lat = 0; busy_cnt = 0;
      while (1) begin
         @(negedge clk);
         if (lat == 0) begin
            start = 1'b0;
            a = $urandom; b = $urandom; c = $urandom; mode = 2'($urandom);
         end
         if (inject_at > 0 && lat == inject_at) begin
            start = 1'b1; mode = 2'b10; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
         end else if (inject_at > 0 && lat == inject_at + 1) begin
            start = 1'b0;
         end
         if (busy) busy_cnt++;
         if (done) break;
         if (lat >= 200) begin
            chk("op_timeout", 1, 0);
            break;
         end
         @(posedge clk);
         lat++;
      end
      $display("op mode=%0d a=%h b=%h c=%h -> hi=%h lo=%h flags=%b lat=%0d busy=%0d",
               m, ia, ib, ic, hi, lo, flags, lat, busy_cnt);
   endtask

   task automatic model(input int w, input logic [1:0] m, input logic [63:0] ia, ib, ic,
                        output logic [63:0] elo, ehi, output logic [1:0] efl);
      logic [127:0] mask, pa, pb, p;
      mask = (128'd1 << w) - 128'd1;
      pa = {64'd0, ia} & mask;
      pb = {64'd0, ib} & mask;
      if (m == 2'b11) begin
         if (pa[w-1]) pa = pa | ~mask;
         if (pb[w-1]) pb = pb | ~mask;
      end
      p = pa * pb;
      if (m == 2'b01) p = p + ({64'd0, ic} & mask);
      elo = 64'(p & mask);
      ehi = m[1] ? 64'((p >> w) & mask) : 64'd0;
      efl[1] = m[1] ? ehi[w-1] : elo[w-1];
      efl[0] = m[1] ? ({ehi, elo} == 128'd0) : (elo == 64'd0);
   endtask

   // Starts both sweep instances together and checks each against the model when its Done arrives.
   task automatic sweep_op(input logic [1:0] m, input logic [63:0] ia, ib, ic);
      int n;
      bit got4, got64;
      int lat4, lat64;
      logic [3:0]  r_lo4, r_hi4;
      logic [63:0] r_lo64, r_hi64, elo, ehi;
      logic [1:0]  r_fl4, r_fl64, efl;
      s_mode = m; s_a = ia; s_b = ib; s_c = ic; s_start = 1'b1;
      @(posedge clk);
      n = 0; got4 = 0; got64 = 0; lat4 = -1; lat64 = -1;
      r_lo4 = '0; r_hi4 = '0; r_fl4 = '0; r_lo64 = '0; r_hi64 = '0; r_fl64 = '0;
      while (1) begin
         @(negedge clk);
         if (n == 0) begin
            s_start = 1'b0; s_a = {$urandom, $urandom}; s_b = {$urandom, $urandom};
         end
         if (done4 && !got4) begin
            got4 = 1; lat4 = n; r_lo4 = lo4; r_hi4 = hi4; r_fl4 = fl4;
         end
         if (done64 && !got64) begin
            got64 = 1; lat64 = n; r_lo64 = lo64; r_hi64 = hi64; r_fl64 = fl64;
         end
         if (got64) break;
         if (n >= 200) begin
            chk("sweep_timeout", 1, 0);
            break;
         end
         @(posedge clk);
         n++;
      end
      chk("w4_lat", lat4, 5);
      chk("w64_lat", lat64, 65);
      model(4, m, ia, ib, ic, elo, ehi, efl);
      chk("w4_lo", r_lo4, elo);
      chk("w4_hi", r_hi4, ehi);
      chk("w4_flags", r_fl4, efl);
      model(64, m, ia, ib, ic, elo, ehi, efl);
      chk("w64_lo", r_lo64, elo);
      chk("w64_hi", r_hi64, ehi);
      chk("w64_flags", r_fl64, efl);
      $display("sweep mode=%0d a=%h b=%h c=%h -> w4 hi=%h lo=%h fl=%b | w64 hi=%h lo=%h fl=%b",
               m, ia, ib, ic, r_hi4, r_lo4, r_fl4, r_hi64, r_lo64, r_fl64);
   endtask

   initial begin
      int lat, bc, seen;

      vecs[0] = '{2'd0, 32'd7,          32'd6,          32'd0,          32'h0000_002A, 32'h0,          2'b00};
      vecs[1] = '{2'd3, 32'hFFFF_FFFD,  32'd5,          32'd0,          32'hFFFF_FFF1, 32'hFFFF_FFFF,  2'b10};
      vecs[2] = '{2'd3, 32'h8000_0000,  32'h8000_0000,  32'd0,          32'h0,         32'h4000_0000,  2'b00};
      vecs[3] = '{2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'h0000_0001, 32'hFFFF_FFFE,  2'b10};
      vecs[4] = '{2'd1, 32'd3,          32'd4,          32'hFFFF_FFF4,  32'h0,         32'h0,          2'b01};
      vecs[5] = '{2'd0, 32'h0000_FFFF,  32'h0001_0001,  32'd0,          32'hFFFF_FFFF, 32'h0,          2'b10};
      vecs[6] = '{2'd2, 32'd0,          32'd12345,      32'd0,          32'h0,         32'h0,          2'b01};
      vecs[7] = '{2'd3, 32'd7,          32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF,  2'b10};
      vecs[8] = '{2'd1, 32'h0001_0000,  32'h0001_0000,  32'd5,          32'h0000_0005, 32'h0,          2'b00};
      vecs[9] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'h0000_0001, 32'h0,          2'b00};

      reset = 1'b1; start = 1'b0; mode = '0; a = '0; b = '0; c = '0;
      s_start = 1'b0; s_mode = '0; s_a = '0; s_b = '0; s_c = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lo", lo, 0);
      chk("rst_hi", hi, 0);
      chk("rst_flags", flags, 0);

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, 0, lat, bc);
         chk($sformatf("v%0d_lat", i), lat, 33);
         chk($sformatf("v%0d_busy_cycles", i), bc, 33);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("v%0d_flags", i), flags, vecs[i].fl);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), done, 0);
         chk($sformatf("v%0d_result_hold", i), lo, vecs[i].lo);
      end

      // Back-to-back: second Start issued during the first Done cycle.
      run_op(2'd1, 32'd3, 32'd4, 32'hFFFF_FFF4, 0, lat, bc);
      chk("b2b_first_lo", lo, 0);
      chk("b2b_first_flags", flags, 2'b01);
      run_op(2'd0, 32'd2, 32'd2, 32'd0, 0, lat, bc);
      chk("b2b_lat", lat, 33);
      chk("b2b_busy_cycles", bc, 33);
      chk("b2b_lo", lo, 4);
      chk("b2b_flags", flags, 2'b00);
      @(negedge clk);

      // Start pulsed mid-RUN with other operands is ignored and not queued.
      run_op(2'd0, 32'd7, 32'd6, 32'd0, 10, lat, bc);
      chk("midstart_lat", lat, 33);
      chk("midstart_lo", lo, 32'h2A);
      chk("midstart_hi", hi, 0);
      @(negedge clk);
      chk("midstart_no_requeue", busy, 0);
      @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      mode = 2'd3; a = 32'hFFFF_FFFD; b = 32'd5; c = 0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_flags", flags, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("midrst_no_done", seen, 0);
      run_op(2'd0, 32'd9, 32'd9, 32'd0, 0, lat, bc);
      chk("after_rst_lat", lat, 33);
      chk("after_rst_lo", lo, 81);
      @(negedge clk);

      // Width sweep: fixed corners then random operands in every mode.
      sweep_op(2'd3, 64'h8000_0000_0000_0008, 64'h8000_0000_0000_0008, 64'd0);
      sweep_op(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      sweep_op(2'd1, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFF4);
      for (int r = 0; r < 3; r++) begin
         for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            sweep_op(2'(m), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
